// File: rtl/logic_pkg.sv
// Shared types for the logic-unit arbiter: request bundle, opcode encoding and source indices.
// The request struct is sized by the package widths. The top-level WIDTH and TAG_W must equal them.
package logic_pkg;

  localparam int LOGIC_WIDTH = 64;
  localparam int LOGIC_TAG_W = 5;

  typedef enum logic {
    OP_AND = 1'b0,
    OP_OR  = 1'b1
  } logic_op_e;

  typedef struct packed {
    logic [LOGIC_WIDTH-1:0] a;
    logic [LOGIC_WIDTH-1:0] b;
    logic_op_e              op;
    logic [LOGIC_TAG_W-1:0] tag;
  } logic_req_t;

  localparam logic SRC_REQ0 = 1'b0;
  localparam logic SRC_REQ1 = 1'b1;

endpackage

// File: rtl/bitwise_AND_OR.sv
// Shared combinational bitwise datapath: A&B when orBit=0, A|B when orBit=1.
module bitwise_AND_OR #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             orBit,
  output logic [WIDTH-1:0] result
);

  assign result = orBit ? (a | b) : (a & b);

endmodule

// File: rtl/logic_rr_arb2.sv
// Two-way round-robin grant. On a tie, the requester that did not win last time is preferred.
module logic_rr_arb2
  import logic_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic       grant,
  output logic       any
);

  logic last_grant;

  always_comb begin
    grant = SRC_REQ0;
    if (valid == 2'b11) begin
      grant = ~last_grant;
    end else if (valid[1]) begin
      grant = SRC_REQ1;
    end
  end

  assign any = |valid;

  // Reset value favours req0 on the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= SRC_REQ1;
    end else if (accept && any) begin
      last_grant <= grant;
    end
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Two requesters share one AND/OR datapath through a round-robin grant.
// The result register is a single stage with backpressure and supports one op per cycle.
module logic_unit_arbiter
  import logic_pkg::*;
#(
  parameter int WIDTH = LOGIC_WIDTH,
  parameter int TAG_W = LOGIC_TAG_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_op,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_op,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_src,
  output logic             out_zero
);

  logic_req_t       req0_p0;
  logic_req_t       req1_p0;
  logic_req_t       sel_p0;
  logic             grant;
  logic             any;
  logic             slot_free;
  logic             take;
  logic [WIDTH-1:0] dp_result;

  logic             vld_p1;
  logic [WIDTH-1:0] result_p1;
  logic [TAG_W-1:0] tag_p1;
  logic             src_p1;

  // ---- stage p0: arbitration, operand select, datapath ----
  assign req0_p0 = '{a: req0_a, b: req0_b, op: logic_op_e'(req0_op), tag: req0_tag};
  assign req1_p0 = '{a: req1_a, b: req1_b, op: logic_op_e'(req1_op), tag: req1_tag};

  logic_rr_arb2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .valid  ({req1_valid, req0_valid}),
    .accept (take),
    .grant  (grant),
    .any    (any)
  );

  // Reset also masks the handshake so that nothing is accepted while reset is held.
  assign slot_free  = !vld_p1 || out_ready;
  assign take       = any && slot_free && !reset;
  assign req0_ready = take && (grant == SRC_REQ0);
  assign req1_ready = take && (grant == SRC_REQ1);

  assign sel_p0 = (grant == SRC_REQ1) ? req1_p0 : req0_p0;

  bitwise_AND_OR #(
    .WIDTH (WIDTH)
  ) u_dp (
    .a      (sel_p0.a),
    .b      (sel_p0.b),
    .orBit  (sel_p0.op == OP_OR),
    .result (dp_result)
  );

  // ---- stage p1: result register ----
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1    <= 1'b0;
      result_p1 <= '0;
      tag_p1    <= '0;
      src_p1    <= SRC_REQ0;
    end else if (take) begin
      vld_p1    <= 1'b1;
      result_p1 <= dp_result;
      tag_p1    <= sel_p0.tag;
      src_p1    <= grant;
    end else if (out_ready) begin
      vld_p1    <= 1'b0;
    end
  end

  assign out_valid  = vld_p1;
  assign out_result = result_p1;
  assign out_tag    = tag_p1;
  assign out_src    = src_p1;
  assign out_zero   = ~|result_p1;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Self-checking bench for logic_unit_arbiter: vector table, directed multi-cycle sequences, random traffic vs model.
module tb_logic_unit_arbiter;

  localparam int W = 64;
  localparam int T = 5;

  logic         clk = 1'b0;
  logic         reset;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         req0_op, req1_op;
  logic [T-1:0] req0_tag, req1_tag;
  logic         out_valid, out_ready;
  logic [W-1:0] out_result;
  logic [T-1:0] out_tag;
  logic         out_src, out_zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  logic_unit_arbiter #(.WIDTH(W), .TAG_W(T)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_op(req0_op), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_op(req1_op), .req1_tag(req1_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .out_src(out_src), .out_zero(out_zero)
  );

  typedef struct {
    logic         rst;
    logic         v0;
    logic [W-1:0] a0, b0;
    logic         op0;
    logic [T-1:0] tag0;
    logic         v1;
    logic [W-1:0] a1, b1;
    logic         op1;
    logic [T-1:0] tag1;
    logic         ordy;
    logic         e_r0, e_r1;
    logic         e_valid;
    logic [W-1:0] e_result;
    logic [T-1:0] e_tag;
    logic         e_src, e_zero;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rst, input logic v0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                       input logic op0, input logic [T-1:0] tag0, input logic v1,
                       input logic [W-1:0] a1, input logic [W-1:0] b1, input logic op1,
                       input logic [T-1:0] tag1, input logic ordy);
    reset = rst; req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = op0; req0_tag = tag0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = op1; req1_tag = tag1; out_ready = ordy;
  endtask

  task automatic chk_out(input string pfx, input logic v, input logic [W-1:0] r, input logic [T-1:0] t,
                         input logic s);
    chk({pfx, ".valid"}, W'(out_valid), W'(v));
    chk({pfx, ".result"}, out_result, r);
    chk({pfx, ".tag"}, W'(out_tag), W'(t));
    chk({pfx, ".src"}, W'(out_src), W'(s));
    chk({pfx, ".zero"}, W'(out_zero), W'(r == '0));
  endtask

  // Reference model state: contents of the output slot and who won last.
  logic         m_valid;
  logic [W-1:0] m_result;
  logic [T-1:0] m_tag;
  logic         m_src;
  int           m_last;

  localparam logic [W-1:0] ONES = {W{1'b1}};
  localparam logic [W-1:0] HF0  = {(W/8){8'hF0}};
  localparam logic [W-1:0] HFF0 = {8'hFF, {(W-8){1'b0}}};
  localparam logic [W-1:0] HAA  = {(W/8){8'hAA}};
  localparam logic [W-1:0] H55  = {(W/8){8'h55}};

  initial begin
    drive(1, 0, '0, '0, 0, '0, 0, '0, '0, 0, '0, 1);

    // rst v0 a0 b0 op0 tag0 v1 a1 b1 op1 tag1 ordy | r0 r1 valid result tag src zero
    vecs[0] = '{1, 1, HF0, HFF0, 0, 5'd7, 1, HAA, H55, 1, 5'd9, 1, 0, 0, 0, '0, 5'd0, 0, 1};
    vecs[1] = vecs[0];
    vecs[2] = vecs[0];
    vecs[3] = '{0, 1, HF0, HFF0, 0, 5'd7, 0, '0, '0, 0, 5'd0, 1, 1, 0, 1, {4'hF, {(W-4){1'b0}}}, 5'd7, 0, 0};
    vecs[4] = '{0, 1, HF0, HFF0, 1, 5'd7, 0, '0, '0, 0, 5'd0, 1, 1, 0, 1, {8'hFF, {(W/8-1){8'hF0}}} | {4'hF, HF0[W-5:0]}, 5'd7, 0, 0};
    vecs[5] = '{0, 1, HAA, H55, 0, 5'd3, 0, '0, '0, 0, 5'd0, 1, 1, 0, 1, '0, 5'd3, 0, 1};
    vecs[6] = '{0, 0, '0, '0, 0, 5'd0, 1, HAA, H55, 1, 5'd9, 1, 0, 1, 1, ONES, 5'd9, 1, 0};
    vecs[7] = '{0, 0, '0, '0, 0, 5'd0, 0, '0, '0, 0, 5'd0, 1, 0, 0, 0, ONES, 5'd9, 1, 0};

    tick();
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].rst, vecs[i].v0, vecs[i].a0, vecs[i].b0, vecs[i].op0, vecs[i].tag0,
            vecs[i].v1, vecs[i].a1, vecs[i].b1, vecs[i].op1, vecs[i].tag1, vecs[i].ordy);
      #1;
      chk($sformatf("vec%0d.ready0", i), W'(req0_ready), W'(vecs[i].e_r0));
      chk($sformatf("vec%0d.ready1", i), W'(req1_ready), W'(vecs[i].e_r1));
      tick();
      chk_out($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_result, vecs[i].e_tag, vecs[i].e_src);
    end

    // Tie: both continuously valid, consumer always ready -> strict alternation starting with req0.
    drive(1, 0, '0, '0, 0, '0, 0, '0, '0, 0, '0, 1);
    tick();
    drive(0, 1, 64'h0F0F, 64'h00FF, 0, 5'd10, 1, 64'hF000, 64'h0F00, 1, 5'd20, 1);
    for (int k = 0; k < 6; k++) begin
      logic g;
      g = logic'(k % 2);
      #1;
      chk($sformatf("tie%0d.ready0", k), W'(req0_ready), W'(!g));
      chk($sformatf("tie%0d.ready1", k), W'(req1_ready), W'(g));
      tick();
      chk_out($sformatf("tie%0d", k), 1, g ? 64'hFF00 : 64'h000F, g ? 5'd20 : 5'd10, g);
    end

    // Backpressure: held result, no ready while stalled, then round-robin resumes at req1.
    drive(1, 0, '0, '0, 0, '0, 0, '0, '0, 0, '0, 1);
    tick();
    drive(0, 1, 64'h1234, ONES, 0, 5'd1, 0, '0, '0, 0, '0, 0);
    #1;
    chk("bp.first_ready0", W'(req0_ready), 1);
    tick();
    chk_out("bp.load", 1, 64'h1234, 5'd1, 0);
    drive(0, 1, 64'h00FF, 64'h0F0F, 0, 5'd2, 1, 64'h5500, 64'h00AA, 1, 5'd3, 0);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("bp%0d.ready0", k), W'(req0_ready), 0);
      chk($sformatf("bp%0d.ready1", k), W'(req1_ready), 0);
      tick();
      chk_out($sformatf("bp%0d", k), 1, 64'h1234, 5'd1, 0);
    end
    out_ready = 1;
    #1;
    chk("bp.resume_ready0", W'(req0_ready), 0);
    chk("bp.resume_ready1", W'(req1_ready), 1);
    tick();
    chk_out("bp.resume", 1, 64'h55AA, 5'd3, 1);

    // Reset during a stall drops the result and re-arms req0 priority.
    drive(1, 0, '0, '0, 0, '0, 0, '0, '0, 0, '0, 0);
    tick();
    chk_out("rststall", 0, '0, 5'd0, 0);
    drive(0, 1, 64'h3, 64'h5, 1, 5'd4, 1, 64'h8, 64'h8, 0, 5'd6, 0);
    #1;
    chk("rststall.ready0", W'(req0_ready), 1);
    chk("rststall.ready1", W'(req1_ready), 0);
    tick();
    chk_out("rststall.after", 1, 64'h7, 5'd4, 0);

    // Random traffic against the model. Each requester holds its op until the model says it is taken.
    drive(1, 0, '0, '0, 0, '0, 0, '0, '0, 0, '0, 1);
    tick();
    m_valid = 0; m_result = '0; m_tag = '0; m_src = 0; m_last = 1;
    for (int n = 0; n < 400; n++) begin
      int           win;
      logic         slot, er0, er1;
      logic [W-1:0] r;
      reset     = ($urandom_range(0, 49) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      if (!req0_valid && $urandom_range(0, 1) == 1) begin
        req0_valid = 1; req0_a = {$urandom, $urandom}; req0_b = {$urandom, $urandom};
        req0_op = $urandom_range(0, 1) == 1; req0_tag = T'($urandom);
      end
      if (!req1_valid && $urandom_range(0, 1) == 1) begin
        req1_valid = 1; req1_a = {$urandom, $urandom}; req1_b = {$urandom, $urandom};
        req1_op = $urandom_range(0, 1) == 1; req1_tag = T'($urandom);
      end
      #1;
      slot = !m_valid || out_ready;
      if (req0_valid && req1_valid) win = 1 - m_last;
      else if (req0_valid)          win = 0;
      else if (req1_valid)          win = 1;
      else                          win = -1;
      if (reset || !slot) win = -1;
      er0 = (win == 0);
      er1 = (win == 1);
      chk($sformatf("rnd%0d.ready0", n), W'(req0_ready), W'(er0));
      chk($sformatf("rnd%0d.ready1", n), W'(req1_ready), W'(er1));
      tick();
      if (reset) begin
        m_valid = 0; m_result = '0; m_tag = '0; m_src = 0; m_last = 1;
      end else if (win >= 0) begin
        if (win == 0) r = req0_op ? (req0_a | req0_b) : (req0_a & req0_b);
        else          r = req1_op ? (req1_a | req1_b) : (req1_a & req1_b);
        m_valid = 1; m_result = r; m_tag = (win == 0) ? req0_tag : req1_tag;
        m_src = (win == 1); m_last = win;
        if (win == 0) req0_valid = 0;
        else          req1_valid = 0;
      end else if (out_ready) begin
        m_valid = 0;
      end
      chk_out($sformatf("rnd%0d", n), m_valid, m_result, m_tag, m_src);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
